// File: rtl/alu_result_fifo.sv
// Result FIFO behind the ALU mux. Stores each result with its op select, a saturated N-bit copy and status flags.
// Latency: a push into an empty FIFO is visible at the head one cycle later. The head is first-word-fall-through.
// Backpressure: in_ready = !full, with no bypass when full. The producer holds its data until it is accepted.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       producer handshake; res_in (N+2 signed), sel_in (3)
//   out_valid/out_ready     consumer handshake; res_out, op_out, sat_out (N signed),
//                           sat_flag, zero_flag, neg_flag describe the head entry
//   count, full, empty      occupancy status, from registered state only
module alu_result_fifo #(
  parameter int N     = 4,
  parameter int DEPTH = 4   // power of 2, >= 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [N+1:0]        res_in,
  input  logic        [2:0]          sel_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [N+1:0]        res_out,
  output logic        [2:0]          op_out,
  output logic signed [N-1:0]        sat_out,
  output logic                       sat_flag,
  output logic                       zero_flag,
  output logic                       neg_flag,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // N-bit signed limits, sign-extended to the N+2-bit result width.
  localparam logic signed [N+1:0] SAT_MAX = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [N+1:0] SAT_MIN = {3'b111, {(N-1){1'b0}}};

  typedef struct packed {
    logic [N+1:0] res;
    logic [2:0]   op;
    logic [N-1:0] sat;
    logic         sat_flag;
    logic         zero_flag;
    logic         neg_flag;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;

  logic            push;
  logic            pop;
  entry_t          wr_entry;
  entry_t          head;

  // Status comes straight from the registered count.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;

  // There is no bypass. A pop in the same cycle does not open a slot when full.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // The flags are computed once at push time, so the head path stays a plain mux.
  always_comb begin
    wr_entry           = '0;
    wr_entry.res       = res_in;
    wr_entry.op        = sel_in;
    wr_entry.zero_flag = (res_in == '0);
    wr_entry.neg_flag  = res_in[N+1];
    wr_entry.sat       = res_in[N-1:0];
    wr_entry.sat_flag  = 1'b0;
    if (res_in > SAT_MAX) begin
      wr_entry.sat      = {1'b0, {(N-1){1'b1}}};
      wr_entry.sat_flag = 1'b1;
    end else if (res_in < SAT_MIN) begin
      wr_entry.sat      = {1'b1, {(N-1){1'b0}}};
      wr_entry.sat_flag = 1'b1;
    end
  end

  // Storage is not reset. Only the pointers and the count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // The pointers wrap naturally at DEPTH because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head outputs are forced to zero when empty, so stale memory never leaks out.
  always_comb begin
    head = mem[rd_ptr];
    res_out   = '0;
    op_out    = '0;
    sat_out   = '0;
    sat_flag  = 1'b0;
    zero_flag = 1'b0;
    neg_flag  = 1'b0;
    if (!empty) begin
      res_out   = head.res;
      op_out    = head.op;
      sat_out   = head.sat;
      sat_flag  = head.sat_flag;
      zero_flag = head.zero_flag;
      neg_flag  = head.neg_flag;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [N+1:0]    res_in = '0;
  logic        [2:0]      sel_in = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic signed [N+1:0]    res_out;
  logic        [2:0]      op_out;
  logic signed [N-1:0]    sat_out;
  logic                   sat_flag;
  logic                   zero_flag;
  logic                   neg_flag;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;

  alu_result_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .res_in(res_in), .sel_in(sel_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_out(res_out), .op_out(op_out), .sat_out(sat_out),
    .sat_flag(sat_flag), .zero_flag(zero_flag), .neg_flag(neg_flag),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: one queue of (result, op) pairs in arrival order.
  int q_res[$];
  int q_op[$];

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_of(input int r);
    int hi;
    int lo;
    hi = (1 << (N - 1)) - 1;
    lo = -(1 << (N - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

  task automatic check_outputs();
    int n;
    int h;
    int e_res;
    int e_op;
    int e_sat;
    int e_sf;
    int e_zf;
    int e_nf;
    n = q_res.size();
    e_res = 0; e_op = 0; e_sat = 0; e_sf = 0; e_zf = 0; e_nf = 0;
    if (n > 0) begin
      h     = q_res[0];
      e_res = h;
      e_op  = q_op[0];
      e_sat = sat_of(h);
      e_sf  = (e_sat != h) ? 1 : 0;
      e_zf  = (h == 0) ? 1 : 0;
      e_nf  = (h < 0) ? 1 : 0;
    end
    check_val("count",     count,     n);
    check_val("empty",     empty,     (n == 0) ? 1 : 0);
    check_val("full",      full,      (n == DEPTH) ? 1 : 0);
    check_val("in_ready",  in_ready,  (n < DEPTH) ? 1 : 0);
    check_val("out_valid", out_valid, (n > 0) ? 1 : 0);
    check_val("res_out",   $signed(res_out), e_res);
    check_val("op_out",    op_out,    e_op);
    check_val("sat_out",   $signed(sat_out), e_sat);
    check_val("sat_flag",  sat_flag,  e_sf);
    check_val("zero_flag", zero_flag, e_zf);
    check_val("neg_flag",  neg_flag,  e_nf);
  endtask

  // One clock with the current inputs: update the model at the edge, then check at the negedge.
  task automatic cycle();
    bit do_push;
    bit do_pop;
    int r;
    int s;
    do_push = in_valid && (q_res.size() < DEPTH);
    do_pop  = out_ready && (q_res.size() > 0);
    r = res_in;
    s = sel_in;
    @(posedge clk);
    if (do_pop) begin
      void'(q_res.pop_front());
      void'(q_op.pop_front());
    end
    if (do_push) begin
      q_res.push_back(r);
      q_op.push_back(s);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit iv, input int v, input int s, input bit ordy);
    in_valid  = iv;
    res_in    = (N+2)'(v);
    sel_in    = 3'(s);
    out_ready = ordy;
  endtask

  int exp_res[4] = '{10, 20, -20, 31};
  int exp_sat[4] = '{7, 7, -8, 7};

  initial begin
    // Reset held for three cycles, then released away from the edge.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs();

    // Store two entries, then assert reset mid-cycle. The outputs must clear with no edge.
    drive(1, 9, 1, 0); cycle();
    drive(1, -3, 4, 0); cycle();
    check_val("pre_rst_count", count, 2);
    drive(0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q_res.delete();
    q_op.delete();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single entries, with constant expectations for the flag cases.
    drive(1, -13, 3'b010, 0); cycle();
    check_val("m13_res", $signed(res_out), -13);
    check_val("m13_op",  op_out, 2);
    check_val("m13_sat", $signed(sat_out), -8);
    check_val("m13_sf",  sat_flag, 1);
    check_val("m13_nf",  neg_flag, 1);
    check_val("m13_zf",  zero_flag, 0);
    drive(1, 5, 1, 1); cycle();
    check_val("p5_sat", $signed(sat_out), 5);
    check_val("p5_sf",  sat_flag, 0);
    drive(1, 0, 6, 1); cycle();
    check_val("z_zf", zero_flag, 1);
    drive(0, 0, 0, 1); cycle();
    check_val("z_empty", empty, 1);

    // Fill to full, then hold a pending value while full.
    for (int i = 0; i < 4; i++) begin
      drive(1, exp_res[i], i, 0);
      cycle();
    end
    check_val("fill_full", full, 1);
    check_val("fill_count", count, 4);
    check_val("fill_rdy", in_ready, 0);
    drive(1, 7, 5, 0);
    repeat (3) cycle();
    check_val("hold_count", count, 4);
    check_val("hold_head", $signed(res_out), 10);

    // Drain in order.
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      check_val("drain_res", $signed(res_out), exp_res[i]);
      check_val("drain_sat", $signed(sat_out), exp_sat[i]);
      cycle();
    end
    check_val("drain_empty", empty, 1);

    // A pop while full frees exactly one slot after the edge. The push that cycle is refused.
    for (int i = 0; i < 4; i++) begin
      drive(1, i + 1, i, 0);
      cycle();
    end
    drive(1, 7, 7, 1);
    check_val("full_rdy_before", in_ready, 0);
    cycle();
    check_val("full_pop_count", count, 3);
    check_val("full_pop_rdy", in_ready, 1);
    check_val("full_pop_head", $signed(res_out), 2);

    // Random traffic over many pointer wraps.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), int'($signed(6'($urandom))),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < 45));
      cycle();
    end
    drive(0, 0, 0, 1);
    repeat (DEPTH + 1) cycle();
    check_val("final_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
